mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch requester and its data (MEM-stage) requester.
- Serialises requests with one transaction outstanding. Data has priority, bounded by an anti-starvation streak counter.
- Returns read data with a one-cycle ack pulse per requester, and provides stall outputs for the pipeline control logic.

Parameters:
- MEM_LATENCY, 1: cycles from mem_en assertion to valid mem_rdata; legal values are 1 or more.
- STREAK_MAX, 4: maximum consecutive data grants while if_req is pending; legal values are 1 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; level signal, held until if_ack
- if_addr  input  32  fetch address
- if_ack  output  1  one-cycle pulse; if_rdata valid during this cycle
- if_rdata  output  32  fetched word, held until the next if_ack
- if_stall  output  1  if_req & ~if_ack (combinational)
- d_req  input  1  data request; level signal, held until d_ack
- d_we  input  1  1 = write, 0 = read
- d_size  input  2  access size, passed through to mem_size
- d_addr  input  32  data address
- d_wdata  input  32  store data
- d_ack  output  1  one-cycle pulse
- d_rdata  output  32  load data, held until the next read d_ack
- d_stall  output  1  d_req & ~d_ack (combinational)
- mem_en  output  1  memory access strobe, exactly one cycle per transaction
- mem_we  output  1  write enable, valid with mem_en
- mem_size  output  2  access size; IF transactions use 2'b10 (word)
- mem_addr  output  32  address, valid with mem_en
- mem_wdata  output  32  write data, valid with mem_en
- mem_rdata  input  32  read data, valid MEM_LATENCY cycles after the mem_en cycle

Behaviour:
- All outputs except if_stall and d_stall are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - With no request pending, stay in IDLE.
  - Otherwise select a winner, latch its addr/we/size/wdata and a grant-owner bit, then go to ISSUE.
- Arbitration:
  - Only d_req high: data wins. Only if_req high: IF wins.
  - Both high: data wins, unless streak == STREAK_MAX, in which case IF wins.
- Streak counter:
  - Increments on a data grant made while if_req is high.
  - Clears on any IF grant, and on a data grant made while if_req is low.
  - Saturates at STREAK_MAX.
- ISSUE:
  - mem_en=1 for exactly this cycle, with latched mem_we/mem_size/mem_addr/mem_wdata.
  - Load latency counter with MEM_LATENCY, then go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, capture mem_rdata at the clock edge and go to RESP.
  - Writes skip the capture.
- RESP:
  - Assert if_ack or d_ack, per the owner bit, for one cycle, with captured data on the matching rdata output; then go to IDLE.
  - Reads update the matching rdata output. Writes leave d_rdata unchanged.
- Total latency: request sampled in IDLE at cycle T means mem_en at T+1 and ack at T+1+MEM_LATENCY+1. For MEM_LATENCY=1, ack is at T+3.
- Requester contract:
  - Hold req and its operands stable until the ack cycle.
  - Deassert req in the cycle after ack unless a new request is presented.
  - A req high in IDLE is always treated as a new request.
  - Operand changes while stalled are ignored; the latched copy is used.
- Only one transaction is outstanding at a time. Requests arriving in ISSUE/WAIT/RESP wait and are evaluated in the next IDLE.
- Minimum spacing between mem_en pulses is MEM_LATENCY+3 cycles.
- Never assert if_ack and d_ack in the same cycle. Never issue mem_en outside ISSUE.
- Reset values: state=IDLE, mem_en=0, mem_we=0, mem_size=0, mem_addr=0, mem_wdata=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, streak=0, latency counter=0.
- Reset mid-transaction (any state) abandons the transaction: no ack is produced, and no further mem_en is issued for it.

Test Plan:
- IF read only, MEM_LATENCY=1: if_req=1, if_addr=0x00000010 at T; memory returns 0x00A00093 at T+2 -> mem_en=1, mem_addr=0x10, mem_size=2'b10 at T+1; if_ack=1, if_rdata=0x00A00093 at T+3; if_stall=1 during T..T+2.
- Data write then read: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_size=2'b10 -> mem_we=1 with mem_en; d_ack after 3 cycles; d_rdata unchanged. Follow with a read of 0x100 -> d_rdata=0xDEADBEEF on d_ack.
- Simultaneous requests: if_req=d_req=1 in the same cycle -> the data transaction is issued first and acked; the IF transaction issues in the following IDLE; acks are never coincident.
- Starvation, STREAK_MAX=4: d_req held with back-to-back new requests, if_req held high -> 4 data grants, then an IF grant, then streak resets and data resumes.
- MEM_LATENCY=3: single IF read -> ack exactly 5 cycles after the request is sampled; mem_rdata is captured only in the cycle 3 after mem_en.
- Reset in WAIT: rst=1 for one cycle during WAIT -> next cycle state=IDLE, all acks=0, mem_en=0, no ack for the abandoned request; a fresh request then completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between instruction fetch and
// the data stage: one transaction in flight, data priority bounded by a streak limit.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int STREAK_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int STK_W = $clog2(STREAK_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [STK_W-1:0] STK_TOP  = STK_W'(STREAK_MAX);
  localparam logic [STK_W-1:0] STK_ONE  = STK_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  logic             r_owner_d;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [STK_W-1:0] r_streak;

  logic w_any_req;
  logic w_grant_d;

  assign w_any_req = if_req | d_req;
  // Data wins unless fetch has been passed over STREAK_MAX times in a row.
  assign w_grant_d = d_req & (~if_req | (r_streak != STK_TOP));

  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner_d <= 1'b0;
      r_lat_cnt <= '0;
      r_streak  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= 2'b00;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= 32'h0;
      d_rdata   <= 32'h0;
    end else begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_d <= w_grant_d;
            mem_en    <= 1'b1;
            r_state   <= S_ISSUE;
            if (w_grant_d) begin
              mem_we    <= d_we;
              mem_size  <= d_size;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (if_req) begin
                if (r_streak != STK_TOP) r_streak <= r_streak + STK_ONE;
              end else begin
                r_streak <= '0;
              end
            end else begin
              mem_we    <= 1'b0;
              mem_size  <= 2'b10;
              mem_addr  <= if_addr;
              mem_wdata <= 32'h0;
              r_streak  <= '0;
            end
          end
        end
        S_ISSUE: begin
          r_lat_cnt <= LAT_LOAD;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt - LAT_ONE;
          // mem_rdata is valid in the cycle where the count sits at one.
          if (r_lat_cnt == LAT_ONE) begin
            r_state <= S_RESP;
            if_ack  <= ~r_owner_d;
            d_ack   <= r_owner_d;
            if (!mem_we) begin
              if (r_owner_d) d_rdata  <= mem_rdata;
              else           if_rdata <= mem_rdata;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_ack_exclusive: assert property (@(posedge clk) disable iff (rst) !(if_ack && d_ack));
  a_en_in_issue:   assert property (@(posedge clk) disable iff (rst) mem_en |-> (r_state == S_ISSUE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: DUT a runs MEM_LATENCY=1, DUT b runs MEM_LATENCY=3, each with a
// memory model that drives garbage on mem_rdata outside the valid cycle.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic        a_if_req, a_if_ack, a_if_stall, a_d_req, a_d_we, a_d_ack, a_d_stall;
  logic        a_mem_en, a_mem_we;
  logic [1:0]  a_d_size, a_mem_size;
  logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_if_req, b_if_ack, b_if_stall, b_d_req, b_d_we, b_d_ack, b_d_stall;
  logic        b_mem_en, b_mem_we;
  logic [1:0]  b_d_size, b_mem_size;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.MEM_LATENCY(1), .STREAK_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
    .if_stall(a_if_stall), .d_req(a_d_req), .d_we(a_d_we), .d_size(a_d_size),
    .d_addr(a_d_addr), .d_wdata(a_d_wdata), .d_ack(a_d_ack), .d_rdata(a_d_rdata),
    .d_stall(a_d_stall), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_size(a_mem_size),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .STREAK_MAX(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .if_stall(b_if_stall), .d_req(b_d_req), .d_we(b_d_we), .d_size(b_d_size),
    .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .d_stall(b_d_stall), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_size(b_mem_size),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [31:0] ad);
    if (ad == 32'h10) return 32'h00A00093;
    return {ad[15:0], ~ad[15:0]};
  endfunction

  // Memory for DUT a: one-cycle read latency, writable.
  logic [31:0] mem_a [256];
  logic        wr_a  [256];
  logic [31:0] a_rd;
  logic        a_rd_vld;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) wr_a[i] <= 1'b0;
      a_rd_vld <= 1'b0;
    end else begin
      a_rd_vld <= a_mem_en & ~a_mem_we;
      if (a_mem_en) begin
        if (a_mem_we) begin
          mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
          wr_a[a_mem_addr[9:2]]  <= 1'b1;
        end else begin
          a_rd <= wr_a[a_mem_addr[9:2]] ? mem_a[a_mem_addr[9:2]] : pat(a_mem_addr);
        end
      end
    end
  end
  assign a_mem_rdata = a_rd_vld ? a_rd : 32'hBADBAD01;

  // Memory for DUT b: three-cycle read latency, read-only pattern.
  logic [31:0] b_pd [3];
  logic        b_pv [3];
  always @(posedge clk) begin
    b_pv[0] <= b_mem_en & ~b_mem_we;
    b_pd[0] <= pat(b_mem_addr);
    for (int i = 1; i < 3; i++) begin
      b_pv[i] <= b_pv[i-1];
      b_pd[i] <= b_pd[i-1];
    end
  end
  assign b_mem_rdata = b_pv[2] ? b_pd[2] : 32'hBADBAD03;

  typedef struct { int cyc; logic is_if; logic [31:0] data; } ack_t;
  typedef struct { int cyc; logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; } en_t;
  ack_t ack_log[$];
  ack_t exp_q[$];
  en_t  en_log[$];

  always @(negedge clk) begin
    if (a_if_ack) ack_log.push_back('{cyc, 1'b1, a_if_rdata});
    if (a_d_ack)  ack_log.push_back('{cyc, 1'b0, a_d_rdata});
    if (a_mem_en) en_log.push_back('{cyc, a_mem_we, a_mem_size, a_mem_addr, a_mem_wdata});
  end

  // Requester drivers: called just after a rising edge, return just after the edge
  // following the ack with the request still raised.
  task automatic d_txn(input logic we, input logic [1:0] sz, input logic [31:0] ad,
                       input logic [31:0] wd, output logic ok);
    a_d_req = 1'b1; a_d_we = we; a_d_size = sz; a_d_addr = ad; a_d_wdata = wd;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (a_d_ack) ok = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic if_txn(input logic [31:0] ad, output logic ok);
    a_if_req = 1'b1; a_if_addr = ad;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (a_if_ack) ok = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if ({a_mem_en, a_mem_we, a_mem_size, a_mem_addr, a_mem_wdata, a_if_ack, a_d_ack,
         a_if_rdata, a_d_rdata, a_if_stall, a_d_stall} !== '0) begin
      bad++;
      $display("FAIL reset_a: outputs got en=%b we=%b size=%b addr=%h wd=%h ack=%b%b rd=%h/%h need all zero",
               a_mem_en, a_mem_we, a_mem_size, a_mem_addr, a_mem_wdata, a_if_ack, a_d_ack, a_if_rdata, a_d_rdata);
    end
    total++;
    if ({b_mem_en, b_mem_we, b_mem_size, b_mem_addr, b_mem_wdata, b_if_ack, b_d_ack,
         b_if_rdata, b_d_rdata, b_if_stall, b_d_stall} !== '0) begin
      bad++;
      $display("FAIL reset_b: outputs got en=%b we=%b size=%b addr=%h wd=%h ack=%b%b rd=%h/%h need all zero",
               b_mem_en, b_mem_we, b_mem_size, b_mem_addr, b_mem_wdata, b_if_ack, b_d_ack, b_if_rdata, b_d_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({a_mem_en, b_mem_en, a_if_ack, a_d_ack} !== 4'b0) begin
        bad++;
        $display("FAIL idle_quiet k=%0d: en_a/en_b/acks got %b need 0000", k, {a_mem_en, b_mem_en, a_if_ack, a_d_ack});
      end
    end
  endtask

  task automatic test_if_read();
    logic [3:0] need, seen;
    @(posedge clk); #1;
    a_if_req = 1'b1; a_if_addr = 32'h10;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      need = {k <= 2, k == 1, k == 3, 1'b0};
      seen = {a_if_stall, a_mem_en, a_if_ack, a_d_ack};
      total++;
      if (seen !== need) begin
        bad++;
        $display("FAIL if_read_ctl k=%0d: stall/en/if_ack/d_ack got %b need %b", k, seen, need);
      end
      if (k == 1) begin
        total++;
        if ({a_mem_we, a_mem_size, a_mem_addr} !== {1'b0, 2'b10, 32'h10}) begin
          bad++;
          $display("FAIL if_read_issue: we/size/addr got %b/%b/%h need 0/10/00000010", a_mem_we, a_mem_size, a_mem_addr);
        end
      end
      if (k == 3) begin
        total++;
        if (a_if_rdata !== 32'h00A00093) begin
          bad++;
          $display("FAIL if_read_data: if_rdata got %h need 00a00093", a_if_rdata);
        end
      end
      @(posedge clk); #1;
      if (k == 0) a_if_addr = 32'h44;
      if (k == 3) a_if_req = 1'b0;
    end
  endtask

  task automatic test_write_read();
    logic ok;
    int   t0;
    ack_t e, got;
    @(posedge clk); #1;
    ack_log.delete(); en_log.delete();
    t0 = cyc;
    exp_q.push_back('{t0 + 3, 1'b0, 32'h0});
    d_txn(1'b1, 2'b10, 32'h100, 32'hDEADBEEF, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wr_timeout: d_ack got none need one"); end
    exp_q.push_back('{t0 + 7, 1'b0, 32'hDEADBEEF});
    d_txn(1'b0, 2'b10, 32'h100, 32'h0, ok);
    exp_q.push_back('{t0 + 11, 1'b0, 32'hDEADBEEF});
    d_txn(1'b0, 2'b01, 32'h100, 32'h0, ok);
    a_d_req = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (ack_log.size() == 0) begin
        bad++;
        $display("FAIL wr_rd_sb: no ack, need if=%0b data=%h cyc=%0d", e.is_if, e.data, e.cyc);
      end else begin
        got = ack_log.pop_front();
        if (got.is_if !== e.is_if || got.data !== e.data || got.cyc != e.cyc) begin
          bad++;
          $display("FAIL wr_rd_sb: got if=%0b data=%h cyc=%0d need if=%0b data=%h cyc=%0d",
                   got.is_if, got.data, got.cyc, e.is_if, e.data, e.cyc);
        end
      end
    end
    total++;
    if (ack_log.size() != 0) begin bad++; $display("FAIL wr_rd_extra: extra acks got %0d need 0", ack_log.size()); end
    total++;
    if (en_log.size() != 3) begin
      bad++;
      $display("FAIL wr_rd_en_count: mem_en pulses got %0d need 3", en_log.size());
    end else begin
      total++;
      if (en_log[0].cyc != t0 + 1 || {en_log[0].we, en_log[0].size, en_log[0].addr, en_log[0].wdata} !==
          {1'b1, 2'b10, 32'h100, 32'hDEADBEEF}) begin
        bad++;
        $display("FAIL wr_issue: cyc=%0d we=%b size=%b addr=%h wd=%h need cyc=%0d 1/10/00000100/deadbeef",
                 en_log[0].cyc, en_log[0].we, en_log[0].size, en_log[0].addr, en_log[0].wdata, t0 + 1);
      end
      total++;
      if (en_log[2].cyc != t0 + 9 || {en_log[2].we, en_log[2].size, en_log[2].addr} !== {1'b0, 2'b01, 32'h100}) begin
        bad++;
        $display("FAIL rd_size_pass: cyc=%0d we=%b size=%b addr=%h need cyc=%0d 0/01/00000100",
                 en_log[2].cyc, en_log[2].we, en_log[2].size, en_log[2].addr, t0 + 9);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic ok_d, ok_i;
    int   t0;
    ack_t e, got;
    @(posedge clk); #1;
    ack_log.delete(); en_log.delete();
    t0 = cyc;
    exp_q.push_back('{t0 + 3, 1'b0, pat(32'h104)});
    exp_q.push_back('{t0 + 7, 1'b1, 32'h00A00093});
    fork
      begin d_txn(1'b0, 2'b10, 32'h104, 32'h0, ok_d); a_d_req = 1'b0; end
      begin if_txn(32'h10, ok_i); a_if_req = 1'b0; end
    join
    total++;
    if (!(ok_d && ok_i)) begin bad++; $display("FAIL sim_timeout: acks got d=%0b if=%0b need 1/1", ok_d, ok_i); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (ack_log.size() == 0) begin
        bad++;
        $display("FAIL sim_sb: no ack, need if=%0b data=%h cyc=%0d", e.is_if, e.data, e.cyc);
      end else begin
        got = ack_log.pop_front();
        if (got.is_if !== e.is_if || got.data !== e.data || got.cyc != e.cyc) begin
          bad++;
          $display("FAIL sim_sb: got if=%0b data=%h cyc=%0d need if=%0b data=%h cyc=%0d",
                   got.is_if, got.data, got.cyc, e.is_if, e.data, e.cyc);
        end
      end
    end
    total++;
    if (ack_log.size() != 0) begin bad++; $display("FAIL sim_extra: extra acks got %0d need 0", ack_log.size()); end
  endtask

  task automatic test_starvation();
    logic ok_d [6];
    logic ok_i;
    logic all_ok;
    int   t0;
    ack_t e, got;
    @(posedge clk); #1;
    ack_log.delete(); en_log.delete();
    t0 = cyc;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) exp_q.push_back('{t0 + 3 + 4 * k, 1'b1, pat(32'h300)});
      else        exp_q.push_back('{t0 + 3 + 4 * k, 1'b0, pat(32'h200 + 4 * (k < 4 ? k : k - 1))});
    end
    fork
      begin
        for (int i = 0; i < 6; i++) d_txn(1'b0, 2'b10, 32'h200 + 4 * i, 32'h0, ok_d[i]);
        a_d_req = 1'b0;
      end
      begin if_txn(32'h300, ok_i); a_if_req = 1'b0; end
    join
    all_ok = ok_i;
    for (int i = 0; i < 6; i++) all_ok = all_ok & ok_d[i];
    total++;
    if (!all_ok) begin bad++; $display("FAIL starve_timeout: transactions got incomplete need all acked"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (ack_log.size() == 0) begin
        bad++;
        $display("FAIL starve_sb: no ack, need if=%0b data=%h cyc=%0d", e.is_if, e.data, e.cyc);
      end else begin
        got = ack_log.pop_front();
        if (got.is_if !== e.is_if || got.data !== e.data || got.cyc != e.cyc) begin
          bad++;
          $display("FAIL starve_sb: got if=%0b data=%h cyc=%0d need if=%0b data=%h cyc=%0d",
                   got.is_if, got.data, got.cyc, e.is_if, e.data, e.cyc);
        end
      end
    end
    total++;
    if (ack_log.size() != 0) begin bad++; $display("FAIL starve_extra: extra acks got %0d need 0", ack_log.size()); end
    total++;
    if (en_log.size() != 7) begin
      bad++;
      $display("FAIL starve_en_count: mem_en pulses got %0d need 7", en_log.size());
    end else begin
      for (int i = 1; i < 7; i++) begin
        total++;
        if (en_log[i].cyc - en_log[i-1].cyc != 4) begin
          bad++;
          $display("FAIL starve_spacing i=%0d: mem_en gap got %0d need 4", i, en_log[i].cyc - en_log[i-1].cyc);
        end
      end
    end
  endtask

  task automatic test_latency3();
    logic [3:0] need, seen;
    @(posedge clk); #1;
    b_if_req = 1'b1; b_if_addr = 32'h20;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      need = {k <= 4, k == 1, k == 5, 1'b0};
      seen = {b_if_stall, b_mem_en, b_if_ack, b_d_ack | b_d_stall};
      total++;
      if (seen !== need) begin
        bad++;
        $display("FAIL lat3_ctl k=%0d: stall/en/if_ack/d got %b need %b", k, seen, need);
      end
      if (k == 1) begin
        total++;
        if ({b_mem_we, b_mem_size, b_mem_addr} !== {1'b0, 2'b10, 32'h20}) begin
          bad++;
          $display("FAIL lat3_issue: we/size/addr got %b/%b/%h need 0/10/00000020", b_mem_we, b_mem_size, b_mem_addr);
        end
      end
      if (k == 5) begin
        total++;
        if (b_if_rdata !== pat(32'h20)) begin
          bad++;
          $display("FAIL lat3_data: if_rdata got %h need %h", b_if_rdata, pat(32'h20));
        end
      end
      @(posedge clk); #1;
      if (k == 5) b_if_req = 1'b0;
    end
  endtask

  task automatic test_reset_wait();
    logic ok;
    int   t0;
    ack_t e, got;
    @(posedge clk); #1;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_size = 2'b10; a_d_addr = 32'h140;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (a_mem_en !== 1'b1) begin bad++; $display("FAIL rstw_issue: mem_en got %b need 1", a_mem_en); end
    @(posedge clk); #1;
    rst = 1'b1; a_d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ack_log.delete(); en_log.delete();
    @(negedge clk);
    total++;
    if ({a_mem_en, a_if_ack, a_d_ack} !== 3'b000) begin
      bad++;
      $display("FAIL rstw_after: en/if_ack/d_ack got %b need 000", {a_mem_en, a_if_ack, a_d_ack});
    end
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (ack_log.size() != 0 || en_log.size() != 0) begin
      bad++;
      $display("FAIL rstw_abandon: acks=%0d mem_en=%0d got need 0/0", ack_log.size(), en_log.size());
    end
    t0 = cyc;
    exp_q.push_back('{t0 + 3, 1'b0, pat(32'h144)});
    d_txn(1'b0, 2'b10, 32'h144, 32'h0, ok);
    a_d_req = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (ack_log.size() == 0) begin
        bad++;
        $display("FAIL rstw_sb: no ack, need if=%0b data=%h cyc=%0d", e.is_if, e.data, e.cyc);
      end else begin
        got = ack_log.pop_front();
        if (got.is_if !== e.is_if || got.data !== e.data || got.cyc != e.cyc) begin
          bad++;
          $display("FAIL rstw_sb: got if=%0b data=%h cyc=%0d need if=%0b data=%h cyc=%0d",
                   got.is_if, got.data, got.cyc, e.is_if, e.data, e.cyc);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_if_req = 1'b0; a_if_addr = 32'h0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_size = 2'b00;
    a_d_addr = 32'h0; a_d_wdata = 32'h0;
    b_if_req = 1'b0; b_if_addr = 32'h0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_size = 2'b00;
    b_d_addr = 32'h0; b_d_wdata = 32'h0;
    test_reset();
    test_if_read();
    test_write_read();
    test_simultaneous();
    test_starvation();
    test_latency3();
    test_reset_wait();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
